// File: rtl/rom_load_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// rom_load_pkg
//   Shared types for the ROM load sequencer: load FSM states, region count
//   and the region descriptor used by the address decoder.
//   Revision: 1.0
// ============================================================================
package rom_load_pkg;

  localparam int NUM_REGIONS = 4;
  localparam int SEL_W       = $clog2(NUM_REGIONS);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD  = ST_HOLD,
    S_RUN   = ST_RUN,
    S_LOAD  = ST_LOAD,
    S_DRAIN = ST_DRAIN
  } load_state_t;

  typedef struct packed {
    logic [24:0] base;
    logic [16:0] size;
  } region_desc_t;

endpackage
`default_nettype wire

// File: rtl/rom_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// rom_load_if
//   HPS download stream plus the region write handshake toward the boards.
//   Revision: 1.0
// ============================================================================
interface rom_load_if;
  import rom_load_pkg::*;

  logic                   ioctl_download;
  logic                   ioctl_wr;
  logic [24:0]            ioctl_addr;
  logic [7:0]             ioctl_dout;
  logic [7:0]             ioctl_index;
  logic                   ioctl_wait;
  logic [NUM_REGIONS-1:0] rom_we;
  logic [15:0]            rom_addr;
  logic [7:0]             rom_data;
  logic [NUM_REGIONS-1:0] tgt_ready;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, tgt_ready,
    input  ioctl_wait, rom_we, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, tgt_ready,
    output ioctl_wait, rom_we, rom_addr, rom_data
  );
endinterface
`default_nettype wire

// File: rtl/rom_load_sequencer_decode.sv
`default_nettype none
// ============================================================================
// rom_region_decode
//   Combinational byte-address to ROM region decoder; lowest index wins.
//   Revision: 1.0
// ============================================================================
module rom_region_decode
  import rom_load_pkg::*;
#(
  parameter region_desc_t [NUM_REGIONS-1:0] REGIONS = '0
) (
  input  logic [24:0]      i_addr,
  output logic             o_match,
  output logic [SEL_W-1:0] o_sel,
  output logic [15:0]      o_local
);

  logic [24:0] w_diff;

  // Scan from the top so the lowest matching region is the last to assign.
  always_comb begin
    o_match = 1'b0;
    o_sel   = '0;
    o_local = '0;
    w_diff  = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      w_diff = i_addr - REGIONS[i].base;
      if (w_diff < {8'd0, REGIONS[i].size}) begin
        o_match = 1'b1;
        o_sel   = SEL_W'(i);
        o_local = w_diff[15:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_load_sequencer.sv
`default_nettype none
// ============================================================================
// rom_load_sequencer
//   Routes the HPS ROM download into board ROM regions through a one-entry
//   write buffer, captures DIP bytes and stretches the game-board reset.
//   Revision: 1.0
// ============================================================================
module rom_load_sequencer
  import rom_load_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [7:0]  DIP_INDEX   = 8'd254,
  parameter logic [24:0] R0_BASE     = 25'h0,
  parameter logic [24:0] R1_BASE     = 25'hC000,
  parameter logic [24:0] R2_BASE     = 25'h1C000,
  parameter logic [24:0] R3_BASE     = 25'h1E000,
  parameter logic [16:0] R0_SIZE     = 17'hC000,
  parameter logic [16:0] R1_SIZE     = 17'h10000,
  parameter logic [16:0] R2_SIZE     = 17'h2000,
  parameter logic [16:0] R3_SIZE     = 17'h1000,
  parameter logic [15:0] HOLD_CYCLES = 16'd1000
) (
  input  logic        clk_sys,
  input  logic        reset,
  rom_load_if.slave   bus,
  output logic        core_reset,
  output logic [63:0] dip_sw,
  output logic [7:0]  unmapped_cnt,
  output logic        proto_err
);

  localparam region_desc_t [NUM_REGIONS-1:0] c_REGIONS =
    {R3_BASE, R3_SIZE, R2_BASE, R2_SIZE, R1_BASE, R1_SIZE, R0_BASE, R0_SIZE};
  localparam logic [15:0] c_HOLD_LOAD = HOLD_CYCLES - 16'd1;

  load_state_t      r_state;
  logic [15:0]      r_cnt;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel;
  logic [15:0]      r_addr;
  logic [7:0]       r_data;
  logic [63:0]      r_dip;
  logic [7:0]       r_unmapped;
  logic             r_perr;

  logic             w_match;
  logic [SEL_W-1:0] w_sel;
  logic [15:0]      w_local;
  logic             w_rom_dl;
  logic             w_dip_wr;
  logic             w_load_wr;
  logic             w_accept;

  rom_region_decode #(
    .REGIONS (c_REGIONS)
  ) u_decode (
    .i_addr  (bus.ioctl_addr),
    .o_match (w_match),
    .o_sel   (w_sel),
    .o_local (w_local)
  );

  assign w_rom_dl  = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
  assign w_dip_wr  = bus.ioctl_wr && bus.ioctl_download &&
                     (bus.ioctl_index == DIP_INDEX) && (bus.ioctl_addr[24:3] == 22'd0);
  assign w_load_wr = (r_state == S_LOAD) && bus.ioctl_wr;
  assign w_accept  = r_valid && bus.tgt_ready[r_sel];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= S_HOLD;
      r_cnt   <= c_HOLD_LOAD;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (w_rom_dl)           r_state <= S_LOAD;
          else if (r_cnt == 16'd0) r_state <= S_RUN;
          else                     r_cnt   <= r_cnt - 16'd1;
        end
        S_RUN:   if (w_rom_dl)              r_state <= S_LOAD;
        S_LOAD:  if (!bus.ioctl_download)   r_state <= S_DRAIN;
        S_DRAIN: begin
          if (!r_valid) begin
            r_state <= S_HOLD;
            r_cnt   <= c_HOLD_LOAD;
          end
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

  // A write seen while the buffer is still valid is dropped, even when the
  // held byte is being accepted in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_unmapped <= '0;
      r_perr     <= 1'b0;
    end else begin
      if (w_accept) r_valid <= 1'b0;
      if (w_load_wr) begin
        if (r_valid) begin
          r_perr <= 1'b1;
        end else if (w_match) begin
          r_valid <= 1'b1;
          r_sel   <= w_sel;
          r_addr  <= w_local;
          r_data  <= bus.ioctl_dout;
        end else if (r_unmapped != 8'hFF) begin
          r_unmapped <= r_unmapped + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)         r_dip <= '0;
    else if (w_dip_wr) r_dip[{bus.ioctl_addr[2:0], 3'b000} +: 8] <= bus.ioctl_dout;
  end

  always_comb begin
    bus.rom_we = '0;
    if (r_valid) bus.rom_we[r_sel] = 1'b1;
  end

  assign bus.rom_addr   = r_addr;
  assign bus.rom_data   = r_data;
  assign bus.ioctl_wait = r_valid;
  assign core_reset     = (r_state != S_RUN);
  assign dip_sw         = r_dip;
  assign unmapped_cnt   = r_unmapped;
  assign proto_err      = r_perr;

endmodule
`default_nettype wire
